pipeline_ctrl: RTL

Central stage-enable scheduler for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Drives the `en` inputs of fetch, decode, execute and memory stages.
- Inserts load-use stalls, flushes wrong-path instructions on EX-resolved redirects, and freezes the pipe while data memory is busy.
- Small registered FSM plus stall counter; all enables are combinational from state and current inputs.

---
 rtl/pipe_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_if.sv | 58 +++++
 rtl/pipeline_ctrl_hazard_detect.sv | 29 ++
 rtl/pipeline_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stage-enable controller: FSM state
// encoding and the RISC-V major opcodes that decode also relies on.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of pipeline-status inputs and stage-enable outputs between the core
// datapath (master) and the stage-enable controller (slave).
// Optional macro PIPE_PERF_COUNTERS_EN adds the stall_cycles / flush_count
// performance counters to the bundle.
interface pipeline_ctrl_if;

    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ready;

    logic        if_en;
    logic        id_en;
    logic        ex_en;
    logic        mem_en;
    logic        id_flush;
    logic        ex_bubble;
    logic [1:0]  ctrl_state;

`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_opcode, ex_rd, ex_redirect, mem_req, mem_ready,
        input  if_en, id_en, ex_en, mem_en, id_flush, ex_bubble, ctrl_state,
        input  stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_opcode, ex_rd, ex_redirect, mem_req, mem_ready,
        output if_en, id_en, ex_en, mem_en, id_flush, ex_bubble, ctrl_state,
        output stall_cycles, flush_count
    );
`else
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_valid, ex_opcode, ex_rd, ex_redirect, mem_req, mem_ready,
        input  if_en, id_en, ex_en, mem_en, id_flush, ex_bubble, ctrl_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_valid, ex_opcode, ex_rd, ex_redirect, mem_req, mem_ready,
        output if_en, id_en, ex_en, mem_en, id_flush, ex_bubble, ctrl_state
    );
`endif

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Kept stand-alone so the forwarding
// unit can reuse the same comparison.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rd,
    output logic       load_hazard
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    always_comb begin
        rs1_match   = id_uses_rs1 && (id_rs1 == ex_rd);
        rs2_match   = id_uses_rs2 && (id_rs2 == ex_rd);
        load_hazard = id_valid && ex_valid && (ex_opcode == OP_LOAD) &&
                      (ex_rd != 5'd0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage-enable scheduler for the 5-stage core: load-use stalls, redirect
// flushes and data-memory freezes. Enables are combinational from the
// registered state and the current inputs.
// Optional macro PIPE_PERF_COUNTERS_EN adds stall/flush performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic           clk,
    input  logic           reset,
    pipeline_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_t     state;
    logic [CNT_W-1:0] cnt;

    logic load_hazard;
    logic mem_stall;
    logic redirect;

    logic if_en;
    logic id_en;
    logic ex_en;
    logic mem_en;
    logic id_flush;
    logic ex_bubble;

    hazard_detect u_hazard_detect (
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_valid    (bus.ex_valid),
        .ex_opcode   (bus.ex_opcode),
        .ex_rd       (bus.ex_rd),
        .load_hazard (load_hazard)
    );

    assign mem_stall = bus.mem_req && !bus.mem_ready;
    assign redirect  = bus.ex_valid && bus.ex_redirect;

    // State and remaining-stall counter; memory busy beats redirect beats hazard
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end else if (!redirect && load_hazard && (LOAD_LAT > 1)) begin
                        state <= LOAD_STALL;
                        cnt   <= CNT_INIT;
                    end
                end
                LOAD_STALL: begin
                    if (mem_stall) begin
                        state <= MEM_WAIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state <= RUN;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state <= (cnt != '0) ? LOAD_STALL : RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Stage enables from current state and inputs; everything low during reset
    always_comb begin
        if_en     = 1'b0;
        id_en     = 1'b0;
        ex_en     = 1'b0;
        mem_en    = 1'b0;
        id_flush  = 1'b0;
        ex_bubble = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        // whole pipe frozen
                    end else if (redirect) begin
                        {if_en, id_en, ex_en, mem_en} = 4'b1111;
                        id_flush  = 1'b1;
                        ex_bubble = 1'b1;
                    end else if (load_hazard) begin
                        ex_en     = 1'b1;
                        mem_en    = 1'b1;
                        ex_bubble = 1'b1;
                    end else begin
                        {if_en, id_en, ex_en, mem_en} = 4'b1111;
                    end
                end
                LOAD_STALL: begin
                    if (!mem_stall) begin
                        ex_en     = 1'b1;
                        mem_en    = 1'b1;
                        ex_bubble = 1'b1;
                    end
                end
                default: begin
                    // MEM_WAIT: frozen until the access completes
                end
            endcase
        end
    end

    assign bus.if_en      = if_en;
    assign bus.id_en      = id_en;
    assign bus.ex_en      = ex_en;
    assign bus.mem_en     = mem_en;
    assign bus.id_flush   = id_flush;
    assign bus.ex_bubble  = ex_bubble;
    assign bus.ctrl_state = state;

`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    // Free-running wrap-around counters of ID-stalled and flush cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!id_en) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (id_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = stall_cycles;
    assign bus.flush_count  = flush_count;
`endif

endmodule
